alu_operand_stage: RTL and testbench

- Decode-to-execute pipeline register that sits directly upstream of the ALU and drives its op1, op2, op and is_cond inputs from registers.
- Selects operands from register-file data, the immediate or the PC.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and stalls when the producer's data is not yet available.
- Uses a valid/ready handshake on both sides, plus a synchronous flush.

---
 rtl/alu_operand_stage.sv | 127 ++++++++++++
 tb/tb_alu_operand_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Decode-to-execute register that feeds ALU operands and forwards from EX/MEM/WB; one-cycle latency.
// Backpressure: in_ready drops on a hazard stall, on flush, or while the held instruction is not consumed.
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 4,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic            in_use_pc,
    input  logic [OPW-1:0]  in_op,
    input  logic            in_is_cond,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_rd_we,
    input  logic            in_is_load,
    input  logic [XLEN-1:0] alu_result,
    input  logic [REGW-1:0] mem_rd,
    input  logic            mem_we,
    input  logic            mem_data_ok,
    input  logic [XLEN-1:0] mem_data,
    input  logic [REGW-1:0] wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [OPW-1:0]  out_op,
    output logic            out_is_cond,
    output logic [REGW-1:0] out_rd,
    output logic            out_rd_we,
    output logic            out_is_load,
    output logic [XLEN-1:0] out_pc
);

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] pc;
        logic [OPW-1:0]  op;
        logic            is_cond;
        logic [REGW-1:0] rd;
        logic            rd_we;
        logic            is_load;
    } exe_t;

    exe_t            held;
    exe_t            nxt;
    logic [XLEN:0]   res1;
    logic [XLEN:0]   res2;
    logic            stall;
    logic            accept;
    logic            out_fire;

    // Returns {stall, value}. The EX-stage result is the ALU output of the
    // instruction we are holding, so it is usable even while it fires.
    function automatic logic [XLEN:0] resolve(input logic            use_s,
                                              input logic [REGW-1:0] s,
                                              input logic [XLEN-1:0] rf);
        logic [XLEN:0] r;
        r = {1'b0, rf};
        if (use_s && (s != '0)) begin
            if (out_valid && held.rd_we && (held.rd == s))
                r = held.is_load ? {1'b1, rf} : {1'b0, alu_result};
            else if (mem_we && (mem_rd == s))
                r = mem_data_ok ? {1'b0, mem_data} : {1'b1, rf};
            else if (wb_we && (wb_rd == s))
                r = {1'b0, wb_data};
        end
        return r;
    endfunction

    always_comb begin
        res1        = resolve(in_use_rs1, in_rs1, in_rs1_data);
        res2        = resolve(in_use_rs2, in_rs2, in_rs2_data);
        stall       = in_valid & (res1[XLEN] | res2[XLEN]);
        nxt         = '0;
        nxt.op1     = in_use_pc  ? in_pc  : res1[XLEN-1:0];
        nxt.op2     = in_use_imm ? in_imm : res2[XLEN-1:0];
        nxt.pc      = in_pc;
        nxt.op      = in_op;
        nxt.is_cond = in_is_cond;
        nxt.rd      = in_rd;
        nxt.rd_we   = in_rd_we;
        nxt.is_load = in_is_load;
    end

    assign in_ready = rst_n & ~flush & ~stall & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            held      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            held      <= nxt;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    assign out_op1     = held.op1;
    assign out_op2     = held.op2;
    assign out_op      = held.op;
    assign out_is_cond = held.is_cond;
    assign out_rd      = held.rd;
    assign out_rd_we   = held.rd_we;
    assign out_is_load = held.is_load;
    assign out_pc      = held.pc;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding/select vector table plus reset, load-use and flush sequences.
module tb_alu_operand_stage;

    logic        clk, rst_n, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm, alu_result, mem_data, wb_data;
    logic [4:0]  in_rs1, in_rs2, in_rd, mem_rd, wb_rd;
    logic        in_use_rs1, in_use_rs2, in_use_imm, in_use_pc, in_is_cond, in_rd_we, in_is_load;
    logic [3:0]  in_op;
    logic        mem_we, mem_data_ok, wb_we;
    logic        out_valid, out_ready, out_is_cond, out_rd_we, out_is_load;
    logic [31:0] out_op1, out_op2, out_pc;
    logic [3:0]  out_op;
    logic [4:0]  out_rd;

    int nvec = 0;
    int nerr = 0;

    alu_operand_stage #(.XLEN(32), .OPW(4), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .in_op(in_op), .in_is_cond(in_is_cond), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_is_load(in_is_load), .alu_result(alu_result),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_data_ok(mem_data_ok), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
        .out_op(out_op), .out_is_cond(out_is_cond), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_is_load(out_is_load), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pre_we, pre_load;
        logic [4:0]  pre_rd;
        logic [31:0] alu;
        logic        mem_we, mem_ok;
        logic [4:0]  mem_rd;
        logic [31:0] mem_dat;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_dat;
        logic        vin;
        logic [4:0]  rs1, rs2;
        logic        use1, use2, use_imm, use_pc;
        logic [31:0] d1, d2, imm, pc;
        logic        exp_rdy, exp_vld;
        logic [31:0] exp1, exp2;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_imm = 0; in_use_imm = 0; in_use_pc = 0; in_op = 0; in_is_cond = 0;
        in_rd = 0; in_rd_we = 0; in_is_load = 0; alu_result = 0;
        mem_rd = 0; mem_we = 0; mem_data_ok = 0; mem_data = 0;
        wb_rd = 0; wb_we = 0; wb_data = 0;
    endtask

    task automatic drain();
        idle();
        out_ready = 1;
        tick();
    endtask

    initial begin
        // pre_we,pre_load,pre_rd,alu | mem_we,ok,rd,dat | wb_we,rd,dat | vin,rs1,rs2,use1,use2,imm,pc | d1,d2,imm,pc | rdy,vld,op1,op2
        vecs[0]  = '{1'b1,1'b0,5'd5,32'h10,   1'b0,1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,  1'b1,5'd5,5'd6,1'b1,1'b0,1'b0,1'b0, 32'h0,32'h22,32'h0,32'h100, 1'b1,1'b1,32'h10,32'h22};
        vecs[1]  = '{1'b1,1'b0,5'd0,32'h10,   1'b0,1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,  1'b1,5'd0,5'd6,1'b1,1'b0,1'b0,1'b0, 32'h0,32'h22,32'h0,32'h100, 1'b1,1'b1,32'h0,32'h22};
        vecs[2]  = '{1'b1,1'b0,5'd0,32'h10,   1'b1,1'b1,5'd0,32'hBB,     1'b1,5'd0,32'hCC, 1'b1,5'd0,5'd0,1'b1,1'b1,1'b0,1'b0, 32'h55,32'h66,32'h0,32'h100, 1'b1,1'b1,32'h55,32'h66};
        vecs[3]  = '{1'b1,1'b0,5'd7,32'hA,    1'b1,1'b1,5'd7,32'hB,      1'b1,5'd7,32'hC,  1'b1,5'd7,5'd8,1'b1,1'b0,1'b0,1'b0, 32'h0,32'h22,32'h0,32'h0, 1'b1,1'b1,32'hA,32'h22};
        vecs[4]  = '{1'b0,1'b0,5'd7,32'hA,    1'b1,1'b1,5'd7,32'hB,      1'b1,5'd7,32'hC,  1'b1,5'd7,5'd8,1'b1,1'b0,1'b0,1'b0, 32'h0,32'h22,32'h0,32'h0, 1'b1,1'b1,32'hB,32'h22};
        vecs[5]  = '{1'b0,1'b0,5'd7,32'hA,    1'b0,1'b1,5'd7,32'hB,      1'b1,5'd7,32'hC,  1'b1,5'd7,5'd8,1'b1,1'b0,1'b0,1'b0, 32'h0,32'h22,32'h0,32'h0, 1'b1,1'b1,32'hC,32'h22};
        vecs[6]  = '{1'b0,1'b0,5'd7,32'hA,    1'b1,1'b0,5'd7,32'hB,      1'b1,5'd7,32'hC,  1'b1,5'd7,5'd8,1'b1,1'b0,1'b0,1'b0, 32'h0,32'h22,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0};
        vecs[7]  = '{1'b1,1'b1,5'd1,32'hA,    1'b0,1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,  1'b1,5'd1,5'd1,1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0,32'hFFFFFFFC,32'h80, 1'b1,1'b1,32'h80,32'hFFFFFFFC};
        vecs[8]  = '{1'b1,1'b1,5'd3,32'hA,    1'b0,1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,  1'b1,5'd0,5'd3,1'b0,1'b1,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0};
        vecs[9]  = '{1'b1,1'b1,5'd4,32'hA,    1'b0,1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,  1'b1,5'd0,5'd4,1'b0,1'b1,1'b1,1'b0, 32'h0,32'h44,32'h8,32'h0, 1'b0,1'b0,32'h0,32'h0};
        vecs[10] = '{1'b1,1'b0,5'd9,32'h99,   1'b0,1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,  1'b1,5'd0,5'd9,1'b0,1'b1,1'b0,1'b0, 32'h11,32'h0,32'h0,32'h0, 1'b1,1'b1,32'h11,32'h99};
        vecs[11] = '{1'b0,1'b0,5'd0,32'h0,    1'b1,1'b1,5'd12,32'h1234,  1'b0,5'd0,32'h0,  1'b1,5'd0,5'd12,1'b0,1'b1,1'b0,1'b0, 32'h11,32'h0,32'h0,32'h0, 1'b1,1'b1,32'h11,32'h1234};
        vecs[12] = '{1'b1,1'b1,5'd3,32'h0,    1'b0,1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,  1'b0,5'd3,5'd0,1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0, 1'b1,1'b0,32'h0,32'h0};
        vecs[13] = '{1'b1,1'b0,5'd5,32'h10,   1'b0,1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,  1'b1,5'd5,5'd0,1'b0,1'b0,1'b0,1'b0, 32'h33,32'h0,32'h0,32'h0, 1'b1,1'b1,32'h33,32'h0};
        vecs[14] = '{1'b1,1'b0,5'd5,32'h10,   1'b1,1'b0,5'd6,32'h0,      1'b0,5'd0,32'h0,  1'b1,5'd5,5'd6,1'b1,1'b1,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0};

        idle();
        out_ready = 1;
        rst_n = 0;
        tick();
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_out_op1", out_op1, 32'h0);
        chk("rst_out_rd", {27'b0, out_rd}, 32'h0);
        rst_n = 1;
        tick();

        // Asynchronous reset while an instruction is held
        in_valid = 1; in_use_pc = 1; in_pc = 32'h1234; out_ready = 0;
        tick();
        chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        chk("pre_rst_op1", out_op1, 32'h1234);
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_op1", out_op1, 32'h0);
        chk("async_rst_in_ready", {31'b0, in_ready}, 32'h0);
        #1 rst_n = 1;
        in_pc = 32'h99;
        tick();
        chk("post_rst_valid", {31'b0, out_valid}, 32'h1);
        chk("post_rst_op1", out_op1, 32'h99);

        for (int i = 0; i < 15; i++) begin
            drain();
            in_valid = 1; in_rd = vecs[i].pre_rd; in_rd_we = vecs[i].pre_we;
            in_is_load = vecs[i].pre_load; out_ready = 0;
            tick();
            idle();
            alu_result = vecs[i].alu;
            mem_we = vecs[i].mem_we; mem_data_ok = vecs[i].mem_ok;
            mem_rd = vecs[i].mem_rd; mem_data = vecs[i].mem_dat;
            wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_dat;
            in_valid = vecs[i].vin; in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
            in_use_rs1 = vecs[i].use1; in_use_rs2 = vecs[i].use2;
            in_use_imm = vecs[i].use_imm; in_use_pc = vecs[i].use_pc;
            in_rs1_data = vecs[i].d1; in_rs2_data = vecs[i].d2;
            in_imm = vecs[i].imm; in_pc = vecs[i].pc;
            in_op = i[3:0]; in_rd = 5'd16 + i[4:0]; in_rd_we = 1;
            out_ready = 1;
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_rdy});
            tick();
            chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_vld});
            if (vecs[i].exp_vld) begin
                chk($sformatf("v%0d_op1", i), out_op1, vecs[i].exp1);
                chk($sformatf("v%0d_op2", i), out_op2, vecs[i].exp2);
                chk($sformatf("v%0d_op", i), {28'b0, out_op}, i & 15);
                chk($sformatf("v%0d_rd", i), {27'b0, out_rd}, 16 + i);
            end
        end

        // Load-use: stall behind the load, bubble until MEM data arrives
        drain();
        in_valid = 1; in_rd = 3; in_rd_we = 1; in_is_load = 1; out_ready = 0;
        tick();
        idle();
        in_valid = 1; in_rs2 = 3; in_use_rs2 = 1; in_rd = 8; in_rd_we = 1; out_ready = 0;
        #1 chk("lu_blocked_rdy", {31'b0, in_ready}, 32'h0);
        tick();
        chk("lu_held_valid", {31'b0, out_valid}, 32'h1);
        out_ready = 1;
        #1 chk("lu_fire_rdy", {31'b0, in_ready}, 32'h0);
        tick();
        chk("lu_drained", {31'b0, out_valid}, 32'h0);
        mem_rd = 3; mem_we = 1; mem_data_ok = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("lu_wait_rdy", {31'b0, in_ready}, 32'h0);
            chk("lu_wait_valid", {31'b0, out_valid}, 32'h0);
            tick();
        end
        mem_data_ok = 1; mem_data = 32'hDEADBEEF;
        #1 chk("lu_ok_rdy", {31'b0, in_ready}, 32'h1);
        tick();
        chk("lu_ok_valid", {31'b0, out_valid}, 32'h1);
        chk("lu_op2", out_op2, 32'hDEADBEEF);

        // Backpressure holds everything stable; flush then drops it without capture
        drain();
        in_valid = 1; in_use_pc = 1; in_pc = 32'h40; in_use_imm = 1; in_imm = 32'h7;
        in_op = 4'h5; in_rd = 9; in_rd_we = 1; out_ready = 0;
        tick();
        in_pc = 32'h50; in_imm = 32'h8; in_op = 4'h3; in_rd = 2;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
            tick();
            chk("bp_valid", {31'b0, out_valid}, 32'h1);
            chk("bp_op1", out_op1, 32'h40);
            chk("bp_op2", out_op2, 32'h7);
            chk("bp_op", {28'b0, out_op}, 32'h5);
            chk("bp_rd", {27'b0, out_rd}, 32'h9);
            chk("bp_pc", out_pc, 32'h40);
        end
        flush = 1;
        #1 chk("fl_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        chk("fl_valid", {31'b0, out_valid}, 32'h0);
        chk("fl_not_captured", out_op1, 32'h40);
        flush = 0; in_valid = 0;
        tick();
        chk("fl_stays_empty", {31'b0, out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
